// File: rtl/wmst_out_fm_ctrl.sv
// wmst_out_fm_ctrl: write-master controller for output-feature-map tiles.
// Walks Tm maps x Tr rows of a tile and issues one Tc-word burst per row
// to the write DMA engine, waiting for each burst to complete.
// Optional feature: define WMST_FIFO_GATE_EN to hold each burst until the
// output FIFO holds at least one full row (Tc words).
module wmst_out_fm_ctrl #(
   parameter int AW          = 12,
   parameter int CW          = 16,
   parameter int DW          = 32,
   parameter int M           = 32,
   parameter int R           = 64,
   parameter int C           = 32,
   parameter int Tm          = 16,
   parameter int Tr          = 64,
   parameter int Tc          = 16,
   parameter int OUT_FM_BASE = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          store_start,
   output logic          store_done,
   input  logic [CW-1:0] tile_base_m,
   input  logic [CW-1:0] tile_base_row,
   input  logic [CW-1:0] tile_base_col,
   input  logic [AW-1:0] store_fifo_count,
   output logic [DW-1:0] param_waddr,
   output logic [AW-1:0] param_iolen,
   output logic          store_trans_start,
   input  logic          store_trans_done
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      CONFIG,
      TRANS,
      DONE
   } wst_t;

   wst_t          wst;
   wst_t          wst_nxt;
   logic [CW-1:0] tm;
   logic [CW-1:0] tr;
   logic          gate_ok;
   logic          last_burst;
   logic [DW-1:0] addr_words;

`ifdef WMST_FIFO_GATE_EN
   // A burst may only start once a full row is buffered in the FIFO
   logic unused_cfg;
   assign unused_cfg = ^CW'(M);
   assign gate_ok    = (store_fifo_count >= AW'(Tc));
`else
   // FIFO occupancy is not consulted; WAIT always lasts a single cycle
   logic unused_cfg;
   assign unused_cfg = ^{store_fifo_count, CW'(M)};
   assign gate_ok    = 1'b1;
`endif

   assign last_burst = (tm == CW'(Tm - 1)) && (tr == CW'(Tr - 1));
   assign store_done = (wst == DONE);

   // Word address of the current row; wraps modulo 2^DW
   always_comb begin
      addr_words = DW'(OUT_FM_BASE)
                 + (DW'(tile_base_m) + DW'(tm)) * DW'(R) * DW'(C)
                 + (DW'(tile_base_row) + DW'(tr)) * DW'(C)
                 + DW'(tile_base_col);
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wst <= IDLE;
      end else begin
         wst <= wst_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      wst_nxt = wst;
      case (wst)
         IDLE:    if (store_start) wst_nxt = WAIT;
         WAIT:    if (gate_ok) wst_nxt = CONFIG;
         CONFIG:  wst_nxt = TRANS;
         TRANS:   if (store_trans_done) wst_nxt = last_burst ? DONE : WAIT;
         DONE:    wst_nxt = IDLE;
         default: wst_nxt = IDLE;
      endcase
   end

   // Row/map loop counters: advance on each completed burst, clear on DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tm <= '0;
         tr <= '0;
      end else if (wst == DONE) begin
         tm <= '0;
         tr <= '0;
      end else if ((wst == TRANS) && store_trans_done) begin
         if (tr == CW'(Tr - 1)) begin
            tr <= '0;
            tm <= tm + CW'(1);
         end else begin
            tr <= tr + CW'(1);
         end
      end
   end

   // Burst parameters latched in CONFIG; request pulse on the first TRANS cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         param_waddr       <= '0;
         param_iolen       <= '0;
         store_trans_start <= 1'b0;
      end else begin
         store_trans_start <= (wst == CONFIG);
         if (wst == CONFIG) begin
            param_waddr <= addr_words << 2;
            param_iolen <= AW'(Tc);
         end
      end
   end

endmodule

// File: tb/tb_wmst_out_fm_ctrl.sv
// Self-checking bench for wmst_out_fm_ctrl: a cycle-timing model built from
// the burst/tile rules, a per-cycle compare, and directed scenarios with
// hand-computed literal expectations.
module tb_wmst_out_fm_ctrl;

   localparam int TM = 2;
   localparam int TR = 2;
   localparam int TC = 4;
   localparam int RR = 4;
   localparam int CC = 8;
   localparam int BASE = 0;
`ifdef WMST_FIFO_GATE_EN
   localparam bit GATE = 1'b1;
`else
   localparam bit GATE = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        store_start;
   logic        store_done;
   logic [15:0] tile_base_m;
   logic [15:0] tile_base_row;
   logic [15:0] tile_base_col;
   logic [11:0] store_fifo_count;
   logic [31:0] param_waddr;
   logic [11:0] param_iolen;
   logic        store_trans_start;
   logic        store_trans_done;

   wmst_out_fm_ctrl #(
      .AW(12), .CW(16), .DW(32), .M(32), .R(RR), .C(CC),
      .Tm(TM), .Tr(TR), .Tc(TC), .OUT_FM_BASE(BASE)
   ) dut (
      .clk(clk), .rst(rst),
      .store_start(store_start), .store_done(store_done),
      .tile_base_m(tile_base_m), .tile_base_row(tile_base_row),
      .tile_base_col(tile_base_col), .store_fifo_count(store_fifo_count),
      .param_waddr(param_waddr), .param_iolen(param_iolen),
      .store_trans_start(store_trans_start), .store_trans_done(store_trans_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
   endtask

   function automatic logic [31:0] exp_addr(input int idx);
      int m, r;
      m = idx / TR;
      r = idx % TR;
      return 32'((BASE + (int'(tile_base_m) + m) * RR * CC
                  + (int'(tile_base_row) + r) * CC + int'(tile_base_col)) * 4);
   endfunction

   // Timing model: cycles at which each burst request and tile completion must appear
   int m_idle = 1;
   int m_wait_from = -1;
   int m_start_at = -1;
   int m_done_at = -1;
   int m_bidx = 0;
   initial begin
      bit gate;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_idle = 1; m_wait_from = -1; m_start_at = -1; m_done_at = -1; m_bidx = 0;
         end else begin
            gate = GATE ? (32'(store_fifo_count) >= 32'(TC)) : 1'b1;
            if (m_idle == 1 && store_start) begin
               m_idle = 0; m_bidx = 0; m_wait_from = cyc + 1;
            end
            if (m_wait_from >= 0 && cyc >= m_wait_from && gate) begin
               m_start_at = cyc + 2; m_wait_from = -1;
            end
            if (m_start_at >= 0 && cyc >= m_start_at && store_trans_done) begin
               m_start_at = -1;
               m_bidx++;
               if (m_bidx == TM * TR) m_done_at = cyc + 1;
               else m_wait_from = cyc + 1;
            end
            if (m_done_at >= 0 && cyc == m_done_at) begin
               m_done_at = -1; m_idle = 1;
            end
         end
         cyc++;
      end
   end

   // Per-cycle compare against the model; also logs burst requests
   logic [31:0] exp_waddr = '0;
   logic [31:0] exp_iolen = '0;
   int n_starts = 0;
   int n_dones = 0;
   logic [31:0] seen_addr [256];
   int start_cyc [256];
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_waddr = '0;
            exp_iolen = '0;
            chk("rst_start", 32'(store_trans_start), 0);
            chk("rst_done", 32'(store_done), 0);
            chk("rst_waddr", param_waddr, 0);
            chk("rst_iolen", 32'(param_iolen), 0);
         end else begin
            if (cyc == m_start_at) begin
               exp_waddr = exp_addr(m_bidx);
               exp_iolen = 32'(TC);
            end
            chk("trans_start", 32'(store_trans_start), 32'(cyc == m_start_at));
            chk("store_done", 32'(store_done), 32'(cyc == m_done_at));
            chk("param_waddr", param_waddr, exp_waddr);
            chk("param_iolen", 32'(param_iolen), exp_iolen);
            if (store_trans_start && n_starts < 256) begin
               seen_addr[n_starts] = param_waddr;
               start_cyc[n_starts] = cyc;
               n_starts++;
            end
            if (store_done) n_dones++;
         end
      end
   end

   // Write-engine responder: completes each burst resp_delay cycles after its request
   int resp_delay = 5;
   bit resp_double = 1'b0;
   initial begin
      int cnt;
      bit done_now, prev_real;
      cnt = -1;
      prev_real = 1'b0;
      store_trans_done = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         done_now = 1'b0;
         if (rst) begin
            cnt = -1;
            prev_real = 1'b0;
         end else begin
            if (store_trans_start) cnt = resp_delay;
            if (cnt == 0) done_now = 1'b1;
            if (cnt >= 0) cnt--;
            if (resp_double && prev_real) begin
               store_trans_done = 1'b1;
               prev_real = done_now;
               continue;
            end
            prev_real = done_now;
         end
         store_trans_done = done_now;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      store_start = 1'b1;
      tick();
      store_start = 1'b0;
   endtask

   task automatic wait_done(input int target, input string nm);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         #1;
         if (n_dones >= target) break;
      end
      chk(nm, n_dones, target);
   endtask

   task automatic wait_start(input int target, input string nm);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         if (n_starts >= target) break;
      end
      chk(nm, n_starts, target);
   endtask

   initial begin
      int s0, s1, d0, ss, c4, k;
      rst = 1'b1;
      store_start = 1'b0;
      store_fifo_count = 12'd16;
      tile_base_m = 16'd1;
      tile_base_row = 16'd2;
      tile_base_col = 16'd4;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // 1: nominal tile
      s0 = n_starts; d0 = n_dones; ss = cyc;
      pulse_start();
      wait_done(d0 + 1, "s1_done");
      chk("s1_nbursts", n_starts - s0, 4);
      chk("s1_addr0", seen_addr[s0], 208);
      chk("s1_addr1", seen_addr[s0 + 1], 240);
      chk("s1_addr2", seen_addr[s0 + 2], 336);
      chk("s1_addr3", seen_addr[s0 + 3], 368);
      chk("s1_latency", start_cyc[s0] - ss, 3);
      chk("s1_gap", start_cyc[s0 + 1] - start_cyc[s0], 8);
      tick();

      // 2: FIFO gate
      store_fifo_count = 12'd3;
      s0 = n_starts; d0 = n_dones; ss = cyc;
      pulse_start();
      repeat (9) tick();
      chk("s2_starts_short", n_starts - s0, GATE ? 0 : 1);
      store_fifo_count = 12'd4;
      c4 = cyc;
      wait_done(d0 + 1, "s2_done");
      chk("s2_start_cyc", start_cyc[s0], GATE ? c4 + 2 : ss + 3);
      chk("s2_nbursts", n_starts - s0, 4);
      store_fifo_count = 12'd16;
      tick();

      // 3: spurious store_start in TRANS, spurious store_trans_done in WAIT
      resp_double = 1'b1;
      s0 = n_starts; d0 = n_dones;
      pulse_start();
      wait_start(s0 + 1, "s3_first_start");
      tick();
      pulse_start();
      wait_done(d0 + 1, "s3_done");
      repeat (4) tick();
      chk("s3_nbursts", n_starts - s0, 4);
      chk("s3_ndones", n_dones - d0, 1);
      resp_double = 1'b0;

      // 4: reset after the second burst completes
      s0 = n_starts; d0 = n_dones;
      pulse_start();
      k = 0;
      for (int i = 0; i < 200 && k < 2; i++) begin
         @(negedge clk);
         #1;
         if (store_trans_done) k++;
      end
      chk("s4_two_dones", k, 2);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (3) tick();
      chk("s4_no_done", n_dones - d0, 0);
      chk("s4_bursts_pre_rst", n_starts - s0, 2);
      s0 = n_starts; d0 = n_dones;
      pulse_start();
      wait_done(d0 + 1, "s4_done");
      chk("s4_restart_addr", seen_addr[s0], 208);
      chk("s4_nbursts", n_starts - s0, 4);
      tick();

      // 5: back-to-back tiles
      s0 = n_starts; d0 = n_dones;
      pulse_start();
      wait_done(d0 + 1, "s5_done_a");
      tick();
      tile_base_m = 16'd0;
      s1 = n_starts; ss = cyc;
      pulse_start();
      wait_done(d0 + 2, "s5_done_b");
      chk("s5_first_addr_b", seen_addr[s1], 80);
      chk("s5_latency_b", start_cyc[s1] - ss, 3);
      chk("s5_nbursts", n_starts - s0, 8);
      tile_base_m = 16'd1;
      tick();

      // 6: completion coincident with the request
      resp_delay = 0;
      s0 = n_starts; d0 = n_dones;
      pulse_start();
      wait_done(d0 + 1, "s6_done");
      chk("s6_nbursts", n_starts - s0, 4);
      for (int i = 0; i < 3; i++)
         chk("s6_gap", start_cyc[s0 + i + 1] - start_cyc[s0 + i], 3);
      resp_delay = 5;

      repeat (3) tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/wmst_out_fm_ctrl.md
# wmst_out_fm_ctrl

Write-master controller that stores a finished output-feature-map tile from the accelerator's output FIFO back to external memory. It walks the tile row by row, Tm output maps × Tr rows. For each row it issues one burst request of Tc words to the write DMA engine and waits for that burst's completion before moving on. It sits between the tile scheduler (store_start/store_done) and the memory write-transaction engine (store_trans_start/store_trans_done), and mirrors the out-FM read master on the load side.

## Interface
Parameters:
- AW, 12, internal address/length width (word units)
- CW, 16, counter/tile-coordinate width
- DW, 32, memory address width
- M, 32, total output maps
- R, 64, rows per output map
- C, 32, columns per output map
- Tm, 16, output maps per tile
- Tr, 64, rows per tile
- Tc, 16, columns per tile (burst length in words)
- OUT_FM_BASE, 0, word base address of the out-FM region

Ports:
- clk  input  1  clock; one clock domain
- rst  input  1  reset, asynchronous, active-high
- store_start  input  1  pulse; begin storing the current tile
- store_done  output  1  one-cycle pulse; whole tile written
- tile_base_m  input  CW  tile origin, output-map index
- tile_base_row  input  CW  tile origin, row
- tile_base_col  input  CW  tile origin, column
- store_fifo_count  input  AW  words currently held in the output FIFO
- param_waddr  output  DW  burst byte address
- param_iolen  output  AW  burst length in words
- store_trans_start  output  1  one-cycle burst request
- store_trans_done  input  1  one-cycle pulse; current burst complete

## Operation
- State register wst: IDLE, WAIT, CONFIG, TRANS, DONE.
- Loop counters:
  - tr: inner loop, 0..Tr-1.
  - tm: outer loop, 0..Tm-1.
  - Both are CW bits wide and are 0 in IDLE.
- Transitions:
  - IDLE→WAIT on store_start.
  - WAIT→CONFIG when the gate condition holds (see Configuration).
  - CONFIG→TRANS unconditionally.
  - TRANS→WAIT on store_trans_done when the burst is not the last one.
  - TRANS→DONE on store_trans_done for the last burst (tm==Tm-1 && tr==Tr-1).
  - DONE→IDLE unconditionally.
- In CONFIG, registered:
  - param_waddr ← (OUT_FM_BASE + (tile_base_m+tm)·R·C + (tile_base_row+tr)·C + tile_base_col) << 2.
  - The sum is computed in DW bits and wraps modulo 2^DW.
  - param_iolen ← Tc.
- Counter advance: on store_trans_done in TRANS.
  - If tr==Tr-1, tr←0 and tm←tm+1; otherwise tr←tr+1.
  - Counters clear on DONE.
- store_trans_start is registered high for exactly the cycle after CONFIG, i.e. the first TRANS cycle.
- store_done = (wst==DONE).
- tile_base_* are sampled combinationally in CONFIG. The scheduler holds them stable from store_start until store_done.
- store_start is ignored outside IDLE.
- store_trans_done is ignored outside TRANS.
- If store_trans_done arrives in the first TRANS cycle (coincident with store_trans_start), it is accepted.

## Timing
- Reset values:
  - wst=IDLE; tm=tr=0.
  - param_waddr=0, param_iolen=0.
  - store_trans_start=0, store_done=0.
- Reset mid-operation aborts immediately to IDLE. Outputs return to reset values; no store_done is issued.
- Latency with the FIFO gate already satisfied:
  - store_start at cycle 0; WAIT at 1; CONFIG at 2.
  - Cycle 3: store_trans_start=1, param_waddr/param_iolen valid.
- Inter-burst overhead: store_trans_done at cycle t → next store_trans_start at t+3 (WAIT, CONFIG, start).
- Last burst: store_trans_done at cycle t → store_done high at t+1 → IDLE at t+2.
- A new store_start is accepted from t+2.
- param_waddr/param_iolen hold their values until the next CONFIG.

## Configuration
- Macro WMST_FIFO_GATE_EN.
- Defined: WAIT exits only when store_fifo_count ≥ Tc, so every burst finds a full row buffered and never starves the DMA. WAIT persists indefinitely while the count is short.
- Undefined: store_fifo_count is unused and WAIT always exits after one cycle. Timing in "Timing" is unchanged for the gate-satisfied case.

## Test plan
Scenarios 1–5 use Tm=2, Tr=2, Tc=4, R=4, C=8, OUT_FM_BASE=0, tile_base m/row/col = 1/2/4, and store_trans_done returned 5 cycles after each start.

1. Nominal tile.
   - Stimulus: store_fifo_count=16, store_start.
   - Response: exactly 4 store_trans_start pulses with param_waddr 208, 240, 336, 368 and param_iolen=4 each, then one store_done pulse; first start 3 cycles after store_start.
2. FIFO gate (macro defined).
   - Stimulus: store_fifo_count=3 for 10 cycles, then 4.
   - Response: no store_trans_start while count=3; start 2 cycles after count reaches 4. With the macro undefined, the start comes at cycle 3 regardless.
3. Spurious inputs.
   - Stimulus: store_start pulsed during TRANS; store_trans_done pulsed in WAIT.
   - Response: both ignored; still exactly 4 bursts and 1 store_done.
4. Reset mid-tile.
   - Stimulus: rst after the 2nd store_trans_done, then a fresh store_start.
   - Response: all outputs 0, no store_done; the new tile restarts at param_waddr=208.
5. Back-to-back tiles.
   - Stimulus: store_start in the cycle store_done falls (IDLE); second tile with tile_base_m=0.
   - Response: second tile's first param_waddr = (0+16+4)·4 = 80.
6. Done coincident with start.
   - Stimulus: store_trans_done asserted in the same cycle as store_trans_start.
   - Response: accepted; counters advance; next start 3 cycles later.
